// File: rtl/regfile_bypass_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_bypass_sb_if
// Bus bundle for the bypassing register file with busy scoreboard.
//   master : issue/decode/writeback side (drives addresses, writes, alloc, clr)
//   slave  : the register file (drives read data, busy flags, busy count)
// Signals:
//   ra[NR*AW]     read addresses, port k at ra[k*AW +: AW]
//   rd[NR*DW]     read data,      port k at rd[k*DW +: DW]
//   rbusy[NR]     busy flag of each read address
//   we0/wa0/wd0   write port 0
//   we1/wa1/wd1   write port 1 (wins over port 0 on the same address)
//   alloc/alloc_a mark a register as having a pending writer
//   clr           flush all busy bits
//   busy_cnt      registered number of busy registers (0..2^AW)
// -----------------------------------------------------------------------------
interface regfile_bypass_sb_if #(
    parameter int AW = 3,
    parameter int DW = 8,
    parameter int NR = 3
);
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [DW-1:0]    wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [DW-1:0]    wd1;
    logic             alloc;
    logic [AW-1:0]    alloc_a;
    logic             clr;
    logic [AW:0]      busy_cnt;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, alloc, alloc_a, clr,
        input  rd, rbusy, busy_cnt
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, alloc, alloc_a, clr,
        output rd, rbusy, busy_cnt
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// -----------------------------------------------------------------------------
// regfile_bypass_sb
// Multi-port register file: two write ports, NR combinational read ports with
// same-cycle write-to-read bypass, optional hardwired-zero register 0 and a
// per-register busy scoreboard with a registered population count.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears data, busy bits, count)
//   bus    : regfile_bypass_sb_if.slave (reads, writes, alloc, clr, busy_cnt)
// Parameters: AW address width, DW data width, NR read ports (1..8),
//             ZERO_REG=1 makes register 0 read zero, drop writes, never busy.
// -----------------------------------------------------------------------------
module regfile_bypass_sb #(
    parameter int AW       = 3,
    parameter int DW       = 8,
    parameter int NR       = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_bypass_sb_if.slave    bus
);
    localparam int D = 2 ** AW;

    // Count of set bits; sized to hold the full depth D.
    function automatic logic [AW:0] popcount(input logic [D-1:0] v);
        logic [AW:0] c;
        c = {(AW+1){1'b0}};
        for (int i = 0; i < D; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // True when addr is the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 32'sd0) && (addr == {AW{1'b0}});
    endfunction

    logic [DW-1:0]    mem_r [D];
    logic [D-1:0]     busy_r;
    logic [D-1:0]     busy_nxt_s;
    logic [AW:0]      busy_cnt_r;
    logic             we0_eff_s;
    logic             we1_eff_s;
    logic             alloc_eff_s;
    logic [NR*DW-1:0] rd_s;
    logic [NR-1:0]    rbusy_s;

    // Qualify enables: anything aimed at the zero register is dropped.
    always_comb begin
        we0_eff_s   = 1'b0;
        we1_eff_s   = 1'b0;
        alloc_eff_s = 1'b0;
        if (is_zero_reg(bus.wa0)) begin
            we0_eff_s = 1'b0;
        end else begin
            we0_eff_s = bus.we0;
        end
        if (is_zero_reg(bus.wa1)) begin
            we1_eff_s = 1'b0;
        end else begin
            we1_eff_s = bus.we1;
        end
        if (is_zero_reg(bus.alloc_a)) begin
            alloc_eff_s = 1'b0;
        end else begin
            alloc_eff_s = bus.alloc;
        end
    end

    // Data array; port 1 is applied last so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (we0_eff_s) begin
                mem_r[bus.wa0] <= bus.wd0;
            end
            if (we1_eff_s) begin
                mem_r[bus.wa1] <= bus.wd1;
            end
        end
    end

    // Next busy vector: flush beats everything, a new alloc beats a retiring write.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < D; i++) begin
            if (bus.clr) begin
                busy_nxt_s[i] = 1'b0;
            end else if (alloc_eff_s && (bus.alloc_a == AW'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if ((we0_eff_s && (bus.wa0 == AW'(i))) ||
                         (we1_eff_s && (bus.wa1 == AW'(i)))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Busy vector and its count; the count comes from the same next-state
    // vector so the two can never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {D{1'b0}};
            busy_cnt_r <= {(AW+1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    // Read ports: zero register, then port-1 bypass, port-0 bypass, array.
    // A bypassed value is already valid, so its busy flag reads clear.
    always_comb begin
        rd_s    = {(NR*DW){1'b0}};
        rbusy_s = {NR{1'b0}};
        for (int k = 0; k < NR; k++) begin
            if (is_zero_reg(bus.ra[k*AW +: AW])) begin
                rd_s[k*DW +: DW] = {DW{1'b0}};
                rbusy_s[k]       = 1'b0;
            end else if (we1_eff_s && (bus.wa1 == bus.ra[k*AW +: AW])) begin
                rd_s[k*DW +: DW] = bus.wd1;
                rbusy_s[k]       = 1'b0;
            end else if (we0_eff_s && (bus.wa0 == bus.ra[k*AW +: AW])) begin
                rd_s[k*DW +: DW] = bus.wd0;
                rbusy_s[k]       = 1'b0;
            end else begin
                rd_s[k*DW +: DW] = mem_r[bus.ra[k*AW +: AW]];
                rbusy_s[k]       = busy_r[bus.ra[k*AW +: AW]];
            end
        end
    end

    assign bus.rd       = rd_s;
    assign bus.rbusy    = rbusy_s;
    assign bus.busy_cnt = busy_cnt_r;

endmodule
